dac_playback_ctrl: RTL and testbench

//  Sequences audio playback from the sample FIFO into the sigma-delta DACs. Generates the sample-rate

---
 rtl/dac_playback_ctrl.sv | 134 +++++++++++++
 tb/tb_dac_playback_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_playback_ctrl.sv
// Playback sequencer between the sample FIFO and the sigma-delta DAC pair.
// Produces the sample-rate strobe, FIFO reads, DAC reset gating and UART CTS hysteresis.
`timescale 1ns/1ps
module dac_playback_ctrl #(
  parameter int BITS          = 8,
  parameter int CLK_FREQ      = 12_000_000,
  parameter int SAMPLE_RATE   = 11_025,
  parameter int FILL_W        = 14,
  parameter int PREFILL_LEVEL = 8192,
  parameter int LOW_WATER     = 1638,
  parameter int HIGH_WATER    = 11469
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [FILL_W-1:0] fifo_fill,
  input  logic              fifo_empty,
  input  logic [BITS-1:0]   fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [BITS-1:0]   sample_out,
  output logic              sample_tick,
  output logic              dac_reset,
  output logic              rx_allow,
  output logic [1:0]        state,
  output logic [15:0]       underrun_count
);

  localparam int DIV   = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [FILL_W-1:0] PREFILL_L  = FILL_W'(PREFILL_LEVEL);
  localparam logic [FILL_W-1:0] LOW_L      = FILL_W'(LOW_WATER);
  localparam logic [FILL_W-1:0] HIGH_L     = FILL_W'(HIGH_WATER);
  localparam logic [BITS-1:0]   MIDSCALE   = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFILL  = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic             sample_tick_reg;
  logic [BITS-1:0]  sample_reg;
  logic             rd_pending_reg;
  logic             rx_allow_reg;
  logic [15:0]      underrun_cnt_reg;
  logic             rd_go;
  logic             underrun_go;

  // Free-running divider; the strobe is registered off the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_reg    <= CNT_RELOAD;
      sample_tick_reg <= 1'b0;
    end else begin
      sample_tick_reg <= (tick_cnt_reg == '0);
      if (tick_cnt_reg == '0) tick_cnt_reg <= CNT_RELOAD;
      else                    tick_cnt_reg <= tick_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    rd_go       = 1'b0;
    underrun_go = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    state_next = ST_PREFILL;
        ST_PREFILL: if (fifo_fill >= PREFILL_L) state_next = ST_PLAY;
        ST_PLAY: begin
          if (sample_tick_reg) begin
            if (fifo_empty) begin
              state_next  = ST_UNDERRUN;
              underrun_go = 1'b1;
            end else begin
              rd_go = 1'b1;
            end
          end
        end
        ST_UNDERRUN: if (fifo_fill >= PREFILL_L) state_next = ST_PLAY;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // With enable low any in-flight read is dropped and the current sample is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg     <= MIDSCALE;
      rd_pending_reg <= 1'b0;
    end else begin
      rd_pending_reg <= rd_go;
      if (enable) begin
        if (state_reg == ST_IDLE || state_reg == ST_PREFILL || underrun_go)
          sample_reg <= MIDSCALE;
        else if (rd_pending_reg)
          sample_reg <= fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt_reg <= 16'd0;
    end else if (underrun_go && underrun_cnt_reg != 16'hFFFF) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 rx_allow_reg <= 1'b1;
    else if (fifo_fill >= HIGH_L) rx_allow_reg <= 1'b0;
    else if (fifo_fill <= LOW_L)  rx_allow_reg <= 1'b1;
  end

  assign fifo_rd_en     = rd_go;
  assign sample_out     = sample_reg;
  assign sample_tick    = sample_tick_reg;
  assign dac_reset      = (state_reg != ST_PLAY);
  assign rx_allow       = rx_allow_reg;
  assign state          = state_reg;
  assign underrun_count = underrun_cnt_reg;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Scoreboard bench for dac_playback_ctrl: directed stimulus pushes expected output events,
// a negedge monitor pops and compares every observed output change.
`timescale 1ns/1ps
module tb_dac_playback_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  fifo_fill = 6'd0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rd_data = 8'd0;
  logic        fifo_rd_en;
  logic [7:0]  sample_out;
  logic        sample_tick;
  logic        dac_reset;
  logic        rx_allow;
  logic [1:0]  state;
  logic [15:0] underrun_count;

  dac_playback_ctrl #(
    .BITS(8), .CLK_FREQ(400), .SAMPLE_RATE(100), .FILL_W(6),
    .PREFILL_LEVEL(8), .LOW_WATER(4), .HIGH_WATER(12)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_fill(fifo_fill),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .sample_out(sample_out), .sample_tick(sample_tick), .dac_reset(dac_reset),
    .rx_allow(rx_allow), .state(state), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_RD, EV_STATE, EV_SAMPLE, EV_RX, EV_URC} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       tag;   // fill level that caused the change, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic void expect_ev(ev_kind_t k, int v, int t);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.tag  = t;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(ev_kind_t k, int v, int t);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got %s val=%0h tag=%0d, required none", k.name(), v, t);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || (e.tag >= 0 && e.tag != t)) begin
        failures++;
        $display("FAIL event got %s val=%0h tag=%0d, required %s val=%0h tag=%0d",
                 k.name(), v, t, e.kind.name(), e.val, e.tag);
      end else begin
        $display("event %s val=%0h tag=%0d ok", k.name(), v, t);
      end
    end
  endfunction

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endfunction

  logic        mon_en = 1'b0;
  int          cyc;
  logic [1:0]  st_prev;
  logic [7:0]  smp_prev;
  logic        rx_prev;
  logic [15:0] urc_prev;
  int          fill_prev;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (sample_tick) begin
        checks++;
        if (cyc != 4) begin
          failures++;
          $display("FAIL tick_period got=%0d required=4", cyc);
        end
        cyc = 0;
      end else if (cyc > 4) begin
        checks++;
        failures++;
        $display("FAIL tick_missing got no tick after %0d clks, required 4", cyc);
        cyc = 0;
      end
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty || state != 2'd2) begin
          failures++;
          $display("FAIL rd_rule got rd_en with empty=%0b state=%0d, required empty=0 state=2",
                   fifo_empty, state);
        end
        check_ev(EV_RD, 0, -1);
      end
      if (state != st_prev) begin
        check_ev(EV_STATE, int'(state), fill_prev);
        checks++;
        if (dac_reset != (state != 2'd2)) begin
          failures++;
          $display("FAIL dac_reset got=%0b required=%0b", dac_reset, state != 2'd2);
        end
      end
      if (sample_out != smp_prev)     check_ev(EV_SAMPLE, int'(sample_out), -1);
      if (rx_allow != rx_prev)        check_ev(EV_RX, int'(rx_allow), fill_prev);
      if (underrun_count != urc_prev) check_ev(EV_URC, int'(underrun_count), -1);
      st_prev   = state;
      smp_prev  = sample_out;
      rx_prev   = rx_allow;
      urc_prev  = underrun_count;
      fill_prev = int'(fifo_fill);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_start();
    cyc       = -1;
    st_prev   = state;
    smp_prev  = sample_out;
    rx_prev   = rx_allow;
    urc_prev  = underrun_count;
    fill_prev = int'(fifo_fill);
    mon_en    = 1'b1;
  endtask

  task automatic wait_rd(input string name);
    for (int i = 0; i < 12 && !fifo_rd_en; i++) step(1);
    if (!fifo_rd_en) begin
      checks++;
      failures++;
      $display("FAIL %s got no fifo_rd_en within 12 clks, required one", name);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 12 && state != s; i++) step(1);
    if (state != s) begin
      checks++;
      failures++;
      $display("FAIL %s got state=%0d, required %0d within 12 clks", name, state, s);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"}, int'(state), 0);
    chk({pfx, "_sample"}, int'(sample_out), 8'h80);
    chk({pfx, "_rd_en"}, int'(fifo_rd_en), 0);
    chk({pfx, "_tick"}, int'(sample_tick), 0);
    chk({pfx, "_dac_reset"}, int'(dac_reset), 1);
    chk({pfx, "_rx_allow"}, int'(rx_allow), 1);
    chk({pfx, "_urc"}, int'(underrun_count), 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    step(2);
    check_reset_values("reset");
    reset_n = 1'b1;
    mon_start();

    // Idle: ticks only.
    step(40);

    // Prefill to 8, enter PLAY, first read returns 3C.
    fifo_rd_data = 8'h3C;
    enable = 1'b1;
    expect_ev(EV_STATE, 1, -1);
    step(1);
    expect_ev(EV_STATE, 2, 8);
    for (int k = 1; k <= 8; k++) begin
      fifo_fill  = 6'(k);
      fifo_empty = 1'b0;
      step(1);
    end
    expect_ev(EV_RD, 0, -1);
    expect_ev(EV_SAMPLE, 8'h3C, -1);
    wait_rd("rd_first");
    step(1);
    fifo_empty = 1'b1;
    fifo_fill  = 6'd0;

    // Underrun at the next tick, then refill.
    expect_ev(EV_STATE, 3, -1);
    expect_ev(EV_SAMPLE, 8'h80, -1);
    expect_ev(EV_URC, 1, -1);
    wait_state(2'd3, "underrun_entry");
    fifo_rd_data = 8'h55;
    fifo_fill    = 6'd8;
    fifo_empty   = 1'b0;
    expect_ev(EV_STATE, 2, 8);
    step(1);

    // Enable drops the clk after a read: the read data must be discarded.
    expect_ev(EV_RD, 0, -1);
    expect_ev(EV_STATE, 0, -1);
    wait_rd("rd_before_drop");
    step(1);
    enable = 1'b0;
    step(6);
    chk("sample_after_drop", int'(sample_out), 8'h80);

    // rx_allow hysteresis sweep 0->13->3.
    expect_ev(EV_RX, 0, 12);
    expect_ev(EV_RX, 1, 4);
    for (int f = 0; f <= 13; f++) begin
      fifo_fill  = 6'(f);
      fifo_empty = (f == 0);
      step(1);
    end
    for (int f = 12; f >= 3; f--) begin
      fifo_fill = 6'(f);
      step(1);
    end
    step(2);

    // Saturation: preload near the top, then force back-to-back underruns.
    expect_ev(EV_URC, 16'hFFFD, -1);
    dut.underrun_cnt_reg = 16'hFFFD;
    step(1);
    fifo_fill  = 6'd12;
    fifo_empty = 1'b1;
    expect_ev(EV_RX, 0, 12);
    step(3);
    enable = 1'b1;
    expect_ev(EV_STATE, 1, -1);
    expect_ev(EV_STATE, 2, 12);
    step(2);
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_STATE, 3, -1);
      if (i == 0) expect_ev(EV_URC, 16'hFFFE, -1);
      if (i == 1) expect_ev(EV_URC, 16'hFFFF, -1);
      expect_ev(EV_STATE, 2, 12);
      wait_state(2'd3, "sat_underrun");
      wait_state(2'd2, "sat_refill");
    end
    #5;
    chk("urc_saturated", int'(underrun_count), 16'hFFFF);
    chk("play_dac_reset", int'(dac_reset), 0);

    // Asynchronous reset mid-PLAY, between clock edges.
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    enable = 1'b0;
    step(2);
    expect_ev(EV_RX, 0, 12);
    reset_n = 1'b1;
    mon_start();
    step(14);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
